life_gen_engine: RTL and testbench

LIFE_GEN_ENGINE -- requirements
Module: life_gen_engine

---
 rtl/life_gen_engine.sv | 126 ++++++++++++
 tb/tb_life_gen_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_engine.sv
// life_gen_engine: double-buffered Game-of-Life engine computing one full row per cycle
module life_gen_engine #(
    parameter int MAP_WIDTH  = 8,
    parameter int MAP_HEIGHT = 8,
    parameter int ADDR_W     = 8,
    parameter int WRAP       = 1,
    parameter int POP_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_req,
    input  logic              clear_req,
    input  logic [8:0]        birth_mask,
    input  logic [8:0]        survive_mask,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [ADDR_W-1:0] wr_col,
    input  logic              wr_data,
    input  logic [ADDR_W-1:0] rd_row,
    input  logic [ADDR_W-1:0] rd_col,
    output logic              rd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       gen_count,
    output logic [POP_W-1:0]  pop_count
);
    localparam int RW = $clog2(MAP_HEIGHT);
    localparam int CW = $clog2(MAP_WIDTH);
    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;
    state_t state;
    logic bank_sel;
    logic [MAP_WIDTH-1:0] bank0 [MAP_HEIGHT];
    logic [MAP_WIDTH-1:0] bank1 [MAP_HEIGHT];
    logic [MAP_WIDTH-1:0] vis [MAP_HEIGHT];
    logic [MAP_WIDTH-1:0] up, mid, dn, nxt;
    logic [RW-1:0] row;
    logic [8:0] birth_q, survive_q;
    logic [POP_W-1:0] acc;
    logic wr_ok, rd_ok, old_cell;
    always_comb begin
        for (int r = 0; r < MAP_HEIGHT; r++) vis[r] = bank_sel ? bank1[r] : bank0[r];
    end
    // Off-map rows read as dead unless the map is toroidal
    assign mid = vis[row];
    assign up  = row == '0 ? (WRAP != 0 ? vis[MAP_HEIGHT-1] : '0) : vis[row - RW'(1)];
    assign dn  = row == RW'(MAP_HEIGHT-1) ? (WRAP != 0 ? vis[0] : '0) : vis[row + RW'(1)];
    genvar c;
    generate
        for (c = 0; c < MAP_WIDTH; c++) begin : g_col
            localparam int L = c == 0 ? MAP_WIDTH-1 : c-1;
            localparam int R = c == MAP_WIDTH-1 ? 0 : c+1;
            localparam bit HAS_L = WRAP != 0 || c != 0;
            localparam bit HAS_R = WRAP != 0 || c != MAP_WIDTH-1;
            logic [3:0] n;
            assign n = 4'(up[c]) + 4'(dn[c])
                     + (HAS_L ? 4'(up[L]) + 4'(mid[L]) + 4'(dn[L]) : 4'd0)
                     + (HAS_R ? 4'(up[R]) + 4'(mid[R]) + 4'(dn[R]) : 4'd0);
            assign nxt[c] = mid[c] ? survive_q[n] : birth_q[n];
        end
    endgenerate
    assign rd_ok    = rd_row < ADDR_W'(MAP_HEIGHT) && rd_col < ADDR_W'(MAP_WIDTH);
    assign wr_ok    = wr_row < ADDR_W'(MAP_HEIGHT) && wr_col < ADDR_W'(MAP_WIDTH);
    assign rd_data  = rd_ok ? vis[rd_row[RW-1:0]][rd_col[CW-1:0]] : 1'b0;
    assign old_cell = vis[wr_row[RW-1:0]][wr_col[CW-1:0]];
    assign busy     = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bank_sel  <= 1'b0;
            row       <= '0;
            birth_q   <= '0;
            survive_q <= '0;
            acc       <= '0;
            done      <= 1'b0;
            gen_count <= '0;
            pop_count <= '0;
            for (int r = 0; r < MAP_HEIGHT; r++) begin
                bank0[r] <= '0;
                bank1[r] <= '0;
            end
        end else if (clear_req) begin
            state     <= IDLE;
            bank_sel  <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
            pop_count <= '0;
            for (int r = 0; r < MAP_HEIGHT; r++) begin
                bank0[r] <= '0;
                bank1[r] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_req) begin
                        birth_q   <= birth_mask;
                        survive_q <= survive_mask;
                        row       <= '0;
                        acc       <= '0;
                        state     <= COMPUTE;
                    end else if (wr_en && wr_ok) begin
                        if (bank_sel) bank1[wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_data;
                        else bank0[wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_data;
                        if (wr_data && !old_cell) pop_count <= pop_count + POP_W'(1);
                        else if (!wr_data && old_cell) pop_count <= pop_count - POP_W'(1);
                    end
                end
                COMPUTE: begin
                    if (bank_sel) bank0[row] <= nxt;
                    else bank1[row] <= nxt;
                    acc <= acc + POP_W'($countones(nxt));
                    row <= row + RW'(1);
                    if (row == RW'(MAP_HEIGHT-1)) state <= COMMIT;
                end
                COMMIT: begin
                    pop_count <= acc;
                    bank_sel  <= ~bank_sel;
                    gen_count <= gen_count + 16'd1;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: WRAP=0 and WRAP=1 engines driven in lockstep against an array-based Life model
module tb_life_gen_engine;
    localparam int W = 8, H = 8, PW = 13;
    logic clk = 0, rst = 1, step_req = 0, clear_req = 0, wr_en = 0, wr_data = 0;
    logic [8:0] birth_mask = 0, survive_mask = 0;
    logic [7:0] wr_row = 0, wr_col = 0, rd_row = 0, rd_col = 0;
    logic rd_data [2];
    logic busy [2];
    logic done [2];
    logic [15:0] gen_count [2];
    logic [PW-1:0] pop_count [2];
    int checks = 0, errors = 0;
    bit mdl [2][H][W];
    bit init_map [H][W];
    int mgen [2];
    int mpop [2];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : u
        life_gen_engine #(.MAP_WIDTH(W), .MAP_HEIGHT(H), .ADDR_W(8), .WRAP(g), .POP_W(PW)) dut (
            .clk(clk), .rst(rst), .step_req(step_req), .clear_req(clear_req),
            .birth_mask(birth_mask), .survive_mask(survive_mask),
            .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
            .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data[g]),
            .busy(busy[g]), .done(done[g]), .gen_count(gen_count[g]), .pop_count(pop_count[g]));
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    function automatic int live(int g);
        int s = 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) s += int'(mdl[g][r][c]);
        return s;
    endfunction
    task automatic model_clear();
        for (int g = 0; g < 2; g++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) mdl[g][r][c] = 0;
            mgen[g] = 0;
            mpop[g] = 0;
        end
    endtask
    // One Life generation with index arithmetic; g doubles as the wrap flag
    task automatic model_step(input logic [8:0] b, input logic [8:0] s);
        bit nx [2][H][W];
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    int n = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if (dr != 0 || dc != 0) begin
                                int rr = r + dr, cc = c + dc;
                                if (g == 1) n += int'(mdl[g][(rr + H) % H][(cc + W) % W]);
                                else if (rr >= 0 && rr < H && cc >= 0 && cc < W) n += int'(mdl[g][rr][cc]);
                            end
                    nx[g][r][c] = mdl[g][r][c] ? s[n] : b[n];
                end
        mdl = nx;
        for (int g = 0; g < 2; g++) begin
            mgen[g] = (mgen[g] + 1) % 65536;
            mpop[g] = live(g);
        end
    endtask
    task automatic write_cell(input int r, input int c, input bit d);
        @(negedge clk);
        wr_en = 1; wr_row = 8'(r); wr_col = 8'(c); wr_data = d;
        @(negedge clk);
        wr_en = 0;
        if (r < H && c < W) for (int g = 0; g < 2; g++) begin
            mdl[g][r][c] = d;
            mpop[g] = live(g);
        end
    endtask
    task automatic do_clear();
        @(negedge clk);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        model_clear();
    endtask
    task automatic check_map(input string tag);
        int bad [2] = '{0, 0};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                rd_row = 8'(r); rd_col = 8'(c);
                #1;
                for (int g = 0; g < 2; g++) if (rd_data[g] !== mdl[g][r][c]) bad[g]++;
            end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s map_w%0d", tag, g), bad[g], 0);
            chk($sformatf("%s pop_w%0d", tag, g), 32'(pop_count[g]), mpop[g]);
            chk($sformatf("%s gen_w%0d", tag, g), 32'(gen_count[g]), mgen[g]);
        end
    endtask
    // Accept edge is the first posedge after step_req rises; done must appear H+2 cycles later
    task automatic run_step(input string tag, input logic [8:0] b, input logic [8:0] s, input bit noise);
        int pr = $urandom_range(H-1, 0), pc = $urandom_range(W-1, 0);
        int bad [2] = '{0, 0};
        @(negedge clk);
        birth_mask = b; survive_mask = s; step_req = 1;
        rd_row = 8'(pr); rd_col = 8'(pc);
        for (int n = 1; n <= H + 2; n++) begin
            @(negedge clk);
            step_req = noise && n >= 2 && n <= H + 1;
            wr_en = noise && n >= 2 && n <= H + 1;
            wr_row = 8'($urandom_range(H-1, 0)); wr_col = 8'($urandom_range(W-1, 0));
            wr_data = 1'($urandom);
            if (noise) begin
                birth_mask = 9'($urandom); survive_mask = 9'($urandom);
            end
            #1;
            if (n < H + 2)
                for (int g = 0; g < 2; g++)
                    if (busy[g] !== 1'b1 || done[g] !== 1'b0 || rd_data[g] !== mdl[g][pr][pc]) bad[g]++;
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s in_flight_w%0d", tag, g), bad[g], 0);
            chk($sformatf("%s done_w%0d", tag, g), 32'(done[g]), 1);
            chk($sformatf("%s idle_w%0d", tag, g), 32'(busy[g]), 0);
        end
        model_step(b, s);
        @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) chk($sformatf("%s done_pulse_w%0d", tag, g), 32'(done[g]), 0);
    endtask
    task automatic read_cell(input string tag, input int r, input int c, input int g, input bit exp);
        @(negedge clk);
        rd_row = 8'(r); rd_col = 8'(c);
        #1;
        chk(tag, 32'(rd_data[g]), 32'(exp));
    endtask
    initial begin
        int bad;
        bit seen;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset busy_w%0d", g), 32'(busy[g]), 0);
            chk($sformatf("reset done_w%0d", g), 32'(done[g]), 0);
        end
        check_map("reset");
        rst = 0;
        // Blinker rotates through the centre
        write_cell(3, 2, 1); write_cell(3, 3, 1); write_cell(3, 4, 1);
        check_map("edits");
        run_step("blink_c", 9'h008, 9'h00C, 0);
        check_map("blink_c");
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("blink_c pop3_w%0d", g), 32'(pop_count[g]), 3);
            read_cell($sformatf("blink_c cell23_w%0d", g), 2, 3, g, 1);
            read_cell($sformatf("blink_c cell43_w%0d", g), 4, 3, g, 1);
            read_cell($sformatf("blink_c cell32_w%0d", g), 3, 2, g, 0);
        end
        // Blinker on the top edge separates dead border from torus
        do_clear();
        write_cell(0, 2, 1); write_cell(0, 3, 1); write_cell(0, 4, 1);
        run_step("blink_e", 9'h008, 9'h00C, 0);
        check_map("blink_e");
        chk("blink_e pop_w0", 32'(pop_count[0]), 2);
        chk("blink_e pop_w1", 32'(pop_count[1]), 3);
        read_cell("blink_e cell73_w1", 7, 3, 1, 1);
        read_cell("blink_e cell73_w0", 7, 3, 0, 0);
        // B1/S: a lone cell seeds its full neighbourhood
        do_clear();
        write_cell(4, 4, 1);
        run_step("b1", 9'h002, 9'h000, 0);
        check_map("b1");
        for (int g = 0; g < 2; g++) chk($sformatf("b1 pop8_w%0d", g), 32'(pop_count[g]), 8);
        // Glider returns home after 32 generations on the torus
        do_clear();
        write_cell(0, 1, 1); write_cell(1, 2, 1); write_cell(2, 0, 1); write_cell(2, 1, 1); write_cell(2, 2, 1);
        init_map = mdl[1];
        for (int i = 0; i < 32; i++) begin
            run_step($sformatf("glider%0d", i), 9'h008, 9'h00C, 0);
            chk($sformatf("glider%0d pop5", i), 32'(pop_count[1]), 5);
            if (i % 8 == 7) check_map($sformatf("glider%0d", i));
        end
        bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                rd_row = 8'(r); rd_col = 8'(c);
                #1;
                if (rd_data[1] !== init_map[r][c]) bad++;
            end
        chk("glider home", bad, 0);
        chk("glider gen32", 32'(gen_count[1]), 32);
        // Out-of-range reads and writes
        write_cell(0, 0, 1);
        write_cell(8, 0, 0); write_cell(0, 8, 0); write_cell(200, 200, 0);
        for (int g = 0; g < 2; g++) begin
            read_cell($sformatf("oor r8_w%0d", g), 8, 0, g, 0);
            read_cell($sformatf("oor c8_w%0d", g), 0, 8, g, 0);
            read_cell($sformatf("oor in_w%0d", g), 0, 0, g, 1);
        end
        check_map("oor");
        // clear_req beats wr_en and step_req in the same cycle
        @(negedge clk);
        clear_req = 1; wr_en = 1; wr_row = 1; wr_col = 1; wr_data = 1; step_req = 1;
        @(negedge clk);
        clear_req = 0; wr_en = 0; step_req = 0;
        model_clear();
        #1;
        for (int g = 0; g < 2; g++) chk($sformatf("clr_prio busy_w%0d", g), 32'(busy[g]), 0);
        check_map("clr_prio");
        // Clear on the third COMPUTE cycle aborts the generation
        write_cell(3, 2, 1); write_cell(3, 3, 1); write_cell(3, 4, 1);
        @(negedge clk);
        birth_mask = 9'h008; survive_mask = 9'h00C; step_req = 1;
        @(negedge clk);
        step_req = 0;
        @(negedge clk);
        @(negedge clk);
        clear_req = 1;
        #1;
        for (int g = 0; g < 2; g++) chk($sformatf("abort busy_before_w%0d", g), 32'(busy[g]), 1);
        @(negedge clk);
        clear_req = 0;
        #1;
        for (int g = 0; g < 2; g++) chk($sformatf("abort busy_after_w%0d", g), 32'(busy[g]), 0);
        seen = 0;
        repeat (H + 2) begin
            @(negedge clk);
            #1;
            if (done[0] !== 1'b0 || done[1] !== 1'b0) seen = 1;
        end
        chk("abort no_done", 32'(seen), 0);
        model_clear();
        check_map("abort");
        // Async reset mid-generation
        write_cell(2, 2, 1); write_cell(2, 3, 1); write_cell(3, 2, 1);
        @(negedge clk);
        step_req = 1;
        repeat (4) @(negedge clk);
        step_req = 0;
        #2;
        rst = 1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_mid busy_w%0d", g), 32'(busy[g]), 0);
            chk($sformatf("rst_mid pop_w%0d", g), 32'(pop_count[g]), 0);
        end
        @(negedge clk);
        rst = 0;
        model_clear();
        check_map("rst_mid");
        // Randomised maps and rules, alternating with busy-time noise
        for (int it = 0; it < 8; it++) begin
            if (it % 3 == 0) do_clear();
            for (int k = 0; k < 14; k++) write_cell($urandom_range(H + 1, 0), $urandom_range(W + 1, 0), 1'($urandom));
            check_map($sformatf("rnd%0d pre", it));
            run_step($sformatf("rnd%0d", it), 9'($urandom), 9'($urandom), it[0]);
            check_map($sformatf("rnd%0d", it));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
